// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit with its control FSM.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; signs are applied in a final cycle before the result strobe.
// Optional build macro MD_EARLY_OUT_EN: divide-by-zero, signed overflow and
// zero multiply operands bypass iteration and go straight to DONE.
module md_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result
);
  localparam int W = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;
  state_t r_state, w_state_nx;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_op;
  logic [W-1:0]         r_a, r_opnd, r_hi, r_lo, r_result;
  logic                 r_neg, r_div0, r_ovf, r_mul0, r_busy, r_valid;

  logic         w_accept, w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic         w_div0, w_ovf, w_mul0;
  logic [W-1:0] w_abs_a, w_abs_b;
  logic [W:0]   w_sum, w_rsh, w_diff;
  logic [W-1:0] w_hi_nx, w_lo_nx, w_quo, w_rem, w_final;
  logic [2*W-1:0] w_prod;

  // Results that bypass the arithmetic: zero multiply operand, divide by
  // zero (all ones / dividend) and signed overflow (most-negative / zero).
  function automatic logic [W-1:0] f_special(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic div0);
    if (!op[2]) return '0;
    if (div0)   return op[1] ? a : '1;
    return op[1] ? '0 : MOST_NEG;
  endfunction

  // Accept decode: operand signedness, magnitudes, result sign, special cases
  always_comb begin
    w_accept   = i_start && !i_flush && (r_state == S_IDLE || r_state == S_DONE);
    w_a_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    w_b_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    w_sa       = w_a_signed && i_src_a[W-1];
    w_sb       = w_b_signed && i_src_b[W-1];
    w_abs_a    = w_sa ? -i_src_a : i_src_a;
    w_abs_b    = w_sb ? -i_src_b : i_src_b;
    w_neg      = (i_op[2] && i_op[1]) ? w_sa : (w_sa ^ w_sb);
    w_div0     = i_op[2] && (i_src_b == '0);
    w_ovf      = i_op[2] && !i_op[0] && (i_src_a == MOST_NEG) && (i_src_b == '1);
    w_mul0     = !i_op[2] && ((i_src_a == '0) || (i_src_b == '0));
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_rsh  = {r_hi, r_lo[W-1]};
    w_diff = w_rsh - {1'b0, r_opnd};
    if (r_op[2]) begin
      if (!w_diff[W]) begin
        w_hi_nx = w_diff[W-1:0];
        w_lo_nx = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_nx = w_rsh[W-1:0];
        w_lo_nx = {r_lo[W-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[W:1];
      w_lo_nx = {w_sum[0], r_lo[W-1:1]};
    end
  end

  // Final sign fix-up and half/quotient/remainder selection
  always_comb begin
    w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo  = r_neg ? -r_lo : r_lo;
    w_rem  = r_neg ? -r_hi : r_hi;
    if (r_div0 || r_ovf || r_mul0)  w_final = f_special(r_op, r_a, r_div0);
    else if (r_op[2])               w_final = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00)    w_final = w_prod[W-1:0];
    else                            w_final = w_prod[2*W-1:W];
  end

  // Next-state logic; a COMPUTE cycle with counter at zero is the fix-up cycle
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nx = S_IDLE;
`ifdef MD_EARLY_OUT_EN
        if (w_accept) w_state_nx = (w_div0 || w_ovf || w_mul0) ? S_DONE : S_COMPUTE;
`else
        if (w_accept) w_state_nx = S_COMPUTE;
`endif
      end
      S_COMPUTE: begin
        if (i_flush)            w_state_nx = S_IDLE;
        else if (r_cnt == '0)   w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register with registered busy/valid decodes
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx == S_COMPUTE);
      r_valid <= (w_state_nx == S_DONE);
    end
  end

  // Datapath: latch on accept, iterate in COMPUTE, commit result on DONE entry
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mul0   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= i_op;
      r_a    <= i_src_a;
      r_neg  <= w_neg;
      r_div0 <= w_div0;
      r_ovf  <= w_ovf;
      r_mul0 <= w_mul0;
      r_cnt  <= CNT_LOAD;
      r_hi   <= '0;
      r_opnd <= i_op[2] ? w_abs_b : w_abs_a;
      r_lo   <= i_op[2] ? w_abs_a : w_abs_b;
`ifdef MD_EARLY_OUT_EN
      if (w_div0 || w_ovf || w_mul0) r_result <= f_special(i_op, i_src_a, w_div0);
`endif
    end else if (r_state == S_COMPUTE && !i_flush) begin
      if (r_cnt != '0) begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_result <= w_final;
      end
    end
  end

  assign o_stall  = (r_state == S_IDLE && i_start && !i_flush) || (r_state == S_COMPUTE);
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed bench for md_sequencer with a cycle-level
// reference model (arithmetic from the RV32M rules, timing as a countdown)
// compared on every falling edge, plus literal expectations per operation.
module tb_md_sequencer;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MD_EARLY_OUT_EN
  localparam int SLAT = 0;
  localparam bit EARLY = 1'b1;
`else
  localparam int SLAT = LAT;
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        o_stall, o_busy, o_valid;
  logic [31:0] o_result;

  int total = 0;
  int bad = 0;

  md_sequencer #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
    .i_src_a(a), .i_src_b(b), .i_flush(flush),
    .o_stall(o_stall), .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sx, sy, sq;
    sx = x; sy = y;
    case (o)
      3'd0: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return sp[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
        sq = sx / sy; return sq;
      end
      3'd5: return (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == 32'hFFFF_FFFF) return '0;
        sq = sx % sy; return sq;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2]) return (y == 0) || (!o[0] && x == MIN && y == 32'hFFFF_FFFF);
    return (x == 0) || (y == 0);
  endfunction

  // Reference model: remaining-cycle countdown per accepted operation
  int          m_rem;
  logic        m_valid;
  logic [31:0] m_out, m_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_valid <= 1'b0; m_out <= '0; m_pend <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem <= 0;
        else if (m_rem == 1) begin m_rem <= 0; m_valid <= 1'b1; m_out <= m_pend; end
        else m_rem <= m_rem - 1;
      end else if (start && !flush) begin
        if (EARLY && is_special(op, a, b)) begin
          m_valid <= 1'b1; m_out <= ref_result(op, a, b);
        end else begin
          m_rem <= LAT; m_pend <= ref_result(op, a, b);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_valid", {31'b0, o_valid}, {31'b0, m_valid});
    check("cyc_busy", {31'b0, o_busy}, {31'b0, m_rem > 0});
    check("cyc_stall", {31'b0, o_stall},
          {31'b0, (m_rem > 0) || (!m_valid && start && !flush)});
    check("cyc_result", o_result, m_out);
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    check({name, "_res"}, o_result, exp);
    check({name, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_result", o_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT);
    run_op("mulh",    3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, LAT);
    run_op("mulh_mn", 3'd1, MIN,          MIN,          32'h4000_0000, LAT);
    run_op("mul_big", 3'd0, 32'h1234_5678, 32'h10,      32'h2345_6780, LAT);
    run_op("mul_z",   3'd0, 32'h1234_5678, 32'd0,       32'd0,         SLAT);
    run_op("div_z",   3'd4, 32'h1234_5678, 32'd0,       32'hFFFF_FFFF, SLAT);
    run_op("divu_z",  3'd5, 32'h1234_5678, 32'd0,       32'hFFFF_FFFF, SLAT);
    run_op("rem_z",   3'd6, 32'h1234_5678, 32'd0,       32'h1234_5678, SLAT);
    run_op("remu_z",  3'd7, 32'h1234_5678, 32'd0,       32'h1234_5678, SLAT);
    run_op("div_ov",  3'd4, MIN,          32'hFFFF_FFFF, MIN,          SLAT);
    run_op("rem_ov",  3'd6, MIN,          32'hFFFF_FFFF, 32'd0,        SLAT);
    run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT);
    run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT);
    run_op("divu",    3'd5, 32'd100,      32'd7,        32'd14,        LAT);
    run_op("remu",    3'd7, 32'd100,      32'd7,        32'd2,         LAT);

    // Flush in the tenth COMPUTE cycle of a DIVU
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, o_busy}, 32'd0);
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    check("flush_hold", o_result, 32'd2);
    repeat (40) begin @(posedge clk); #1; end
    check("flush_hold2", o_result, 32'd2);
    start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {31'b0, o_stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, o_busy}, 32'd0);

    // Back-to-back: second request held through the first DONE
    op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd5; a = 32'd100; b = 32'd7;
    wait_valid(n);
    check("b2b_first_res", o_result, 32'd42);
    check("b2b_first_lat", 32'(n), 32'(LAT));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", {31'b0, o_busy}, 32'd1);
    wait_valid(n);
    check("b2b_second_res", o_result, 32'd14);
    check("b2b_second_lat", 32'(n), 32'(LAT));

    // Async reset pulsed mid-COMPUTE
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, o_busy}, 32'd0);
    check("arst_valid", {31'b0, o_valid}, 32'd0);
    check("arst_stall", {31'b0, o_stall}, 32'd0);
    check("arst_result", o_result, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 3'd0, 32'd6, 32'd7, 32'd42, LAT);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
